// File: rtl/biquad_pkg.sv
// Shared types, FSM encoding and coefficient preset table for the biquad sequencer.
// Coefficients are signed 4.14 fixed point.
package biquad_pkg;

  typedef logic signed [17:0] coef_t;

  localparam coef_t COEF_ONE = 18'h04000;

  typedef struct packed {
    coef_t a0;
    coef_t a1;
    coef_t a2;
    coef_t b1;
    coef_t b2;
  } coef_set_t;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SAMP_REQ     = 3'd1,
    SAMP_CAPTURE = 3'd2,
    COEF_REQ     = 3'd3,
    COEF_RELEASE = 3'd4,
    ABORT        = 3'd5
  } seq_state_t;

  localparam int PRESET_DEPTH = 8;

  // Field order in each entry: a0, a1, a2, b1, b2
  localparam coef_set_t PRESET_TABLE [PRESET_DEPTH] = '{
    '{18'h04000, 18'h00000, 18'h00000, 18'h00000, 18'h00000},
    '{18'h02000, 18'h00000, 18'h00000, 18'h00000, 18'h00000},
    '{18'h01000, 18'h02000, 18'h01000, 18'h00000, 18'h00000},
    '{18'h08000, 18'h3F000, 18'h00800, 18'h3E000, 18'h01000},
    '{18'h01000, 18'h02000, 18'h01000, 18'h3E000, 18'h00400},
    '{18'h03000, 18'h3A000, 18'h03000, 18'h3C000, 18'h00C00},
    '{18'h04000, 18'h38000, 18'h04000, 18'h38000, 18'h03000},
    '{18'h00800, 18'h00000, 18'h3F800, 18'h3F000, 18'h00200}
  };

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/biquad_preset_rom.sv
// Combinational preset index to coefficient set lookup; indices beyond the
// populated range fall back to the passthrough preset.
module biquad_preset_rom
  import biquad_pkg::*;
#(
  parameter int NUM_PRESETS = 8
) (
  input  logic [2:0] index,
  output coef_set_t  coefs
);

  // Table lookup with out-of-range fallback
  always_comb begin
    coefs = PRESET_TABLE[0];
    if (int'(index) < NUM_PRESETS) begin
      coefs = PRESET_TABLE[index];
    end else begin
      coefs = PRESET_TABLE[0];
    end
  end

endmodule

// File: rtl/biquad_sequencer.sv
// Feeds strobed samples and coefficient presets to an external biquad through
// level request / acknowledge handshakes, with timeout recovery.
module biquad_sequencer
  import biquad_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int NUM_PRESETS    = 8
) (
  input  logic               CLOCK_50,
  input  logic               Reset,
  input  logic               sample_strobe,
  input  logic signed [15:0] sample_in,
  input  logic               preset_req,
  input  logic [2:0]         preset_sel,
  output logic               bq_new_sample,
  output logic               bq_new_coefficients,
  output logic signed [15:0] bq_sample_in,
  output coef_t              bq_a0_load,
  output coef_t              bq_a1_load,
  output coef_t              bq_a2_load,
  output coef_t              bq_b1_load,
  output coef_t              bq_b2_load,
  input  logic               bq_computation_done,
  input  logic               bq_coefficients_updated,
  input  logic signed [15:0] bq_sample_out,
  output logic signed [15:0] sample_out,
  output logic               sample_valid,
  output logic               busy,
  output logic               fault,
  output logic [7:0]         overrun_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  seq_state_t         state_r;
  logic               samp_pend_r;
  logic signed [15:0] samp_buf_r;
  logic               coef_pend_r;
  logic [2:0]         coef_idx_r;
  logic [TW-1:0]      tmo_cnt_r;
  logic               abort_cnt_r;
  logic               take_sample_s;
  logic               take_coef_s;
  coef_set_t          rom_set_s;

  biquad_preset_rom #(.NUM_PRESETS(NUM_PRESETS)) u_rom (
    .index (coef_idx_r),
    .coefs (rom_set_s)
  );

  // Samples take priority over presets when both are waiting
  always_comb begin
    take_sample_s = 1'b0;
    take_coef_s   = 1'b0;
    if (state_r == IDLE) begin
      take_sample_s = samp_pend_r;
      take_coef_s   = ~samp_pend_r & coef_pend_r;
    end else begin
      take_sample_s = 1'b0;
      take_coef_s   = 1'b0;
    end
  end

  // One-deep sample and preset holding registers; a new arrival beats the
  // consume on the same edge, and overwriting an unconsumed sample is an overrun
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      samp_pend_r   <= 1'b0;
      samp_buf_r    <= 16'sd0;
      coef_pend_r   <= 1'b0;
      coef_idx_r    <= 3'd0;
      overrun_count <= 8'd0;
    end else begin
      if (sample_strobe) begin
        samp_buf_r  <= sample_in;
        samp_pend_r <= 1'b1;
        if (samp_pend_r && !take_sample_s) begin
          overrun_count <= sat_inc8(overrun_count);
        end
      end else if (take_sample_s) begin
        samp_pend_r <= 1'b0;
      end
      if (preset_req) begin
        coef_idx_r  <= preset_sel;
        coef_pend_r <= 1'b1;
      end else if (take_coef_s) begin
        coef_pend_r <= 1'b0;
      end
    end
  end

  // Handshake FSM with registered biquad-side and status outputs
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_r             <= IDLE;
      bq_new_sample       <= 1'b0;
      bq_new_coefficients <= 1'b0;
      bq_sample_in        <= 16'sd0;
      bq_a0_load          <= COEF_ONE;
      bq_a1_load          <= 18'sd0;
      bq_a2_load          <= 18'sd0;
      bq_b1_load          <= 18'sd0;
      bq_b2_load          <= 18'sd0;
      sample_out          <= 16'sd0;
      sample_valid        <= 1'b0;
      busy                <= 1'b0;
      fault               <= 1'b0;
      tmo_cnt_r           <= '0;
      abort_cnt_r         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          tmo_cnt_r   <= '0;
          abort_cnt_r <= 1'b0;
          if (take_sample_s) begin
            bq_sample_in  <= samp_buf_r;
            bq_new_sample <= 1'b1;
            busy          <= 1'b1;
            state_r       <= SAMP_REQ;
          end else if (take_coef_s) begin
            bq_a0_load          <= rom_set_s.a0;
            bq_a1_load          <= rom_set_s.a1;
            bq_a2_load          <= rom_set_s.a2;
            bq_b1_load          <= rom_set_s.b1;
            bq_b2_load          <= rom_set_s.b2;
            bq_new_coefficients <= 1'b1;
            busy                <= 1'b1;
            state_r             <= COEF_REQ;
          end else begin
            busy <= 1'b0;
          end
        end
        SAMP_REQ: begin
          if (bq_computation_done) begin
            bq_new_sample <= 1'b0;
            state_r       <= SAMP_CAPTURE;
          end else if (tmo_cnt_r == TMO_LAST) begin
            bq_new_sample <= 1'b0;
            fault         <= 1'b1;
            state_r       <= ABORT;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
        SAMP_CAPTURE: begin
          sample_out   <= bq_sample_out;
          sample_valid <= 1'b1;
          busy         <= 1'b0;
          state_r      <= IDLE;
        end
        COEF_REQ: begin
          if (bq_coefficients_updated) begin
            bq_new_coefficients <= 1'b0;
            state_r             <= COEF_RELEASE;
          end else if (tmo_cnt_r == TMO_LAST) begin
            bq_new_coefficients <= 1'b0;
            fault               <= 1'b1;
            state_r             <= ABORT;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
        COEF_RELEASE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        // Two quiet cycles so the biquad sees both requests low before retrying
        ABORT: begin
          if (abort_cnt_r) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            abort_cnt_r <= 1'b1;
          end
        end
        default: begin
          bq_new_sample       <= 1'b0;
          bq_new_coefficients <= 1'b0;
          busy                <= 1'b0;
          state_r             <= IDLE;
        end
      endcase
    end
  end

endmodule
